// File: rtl/program_loader_if.sv
// Instruction-field stream from a producer into the program loader.
// master drives the fields, slave (the loader) returns in_ready.
interface program_loader_if #(
  parameter int NumOpCodeBits = 5,
  parameter int SEL_WIDTH     = 2,
  parameter int DataWidth     = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic [NumOpCodeBits-1:0] in_opcode;
  logic [SEL_WIDTH-1:0]     in_op1;
  logic [SEL_WIDTH-1:0]     in_op2;
  logic [DataWidth-1:0]     in_literal;
  logic                     in_last;

  modport master (
    output in_valid, in_opcode, in_op1,
    output in_op2, in_literal, in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_opcode, in_op1,
    input  in_op2, in_literal, in_last,
    output in_ready
  );
endinterface

// File: rtl/program_loader.sv
// Encodes symbolic instruction fields into 16-bit program words and
// writes them to program memory from address 0, holding the CPU meanwhile.
module program_loader #(
  parameter int PC_WIDTH          = 8,
  parameter int PROGRAM_DataWidth = 16,
  parameter int NumOpCodeBits     = 5,
  parameter int SEL_WIDTH         = 2,
  parameter int DataWidth         = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  program_loader_if.slave              s,
  output logic                         mem_wr_en,
  output logic [PC_WIDTH-1:0]          mem_addr,
  output logic [PROGRAM_DataWidth-1:0] mem_wr_data,
  output logic [PC_WIDTH:0]            word_count,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [1:0]                   err_code,
  output logic                         cpu_hold
);

  typedef enum logic [1:0] {
    IDLE, LOAD, DONE, ERROR
  } state_t;

  typedef logic [NumOpCodeBits-1:0] op_t;

  localparam op_t OP_ADD  = op_t'(1);
  localparam op_t OP_REGL = op_t'(6);
  localparam op_t OP_SHL  = op_t'(7);
  localparam op_t OP_VAL  = op_t'(9);
  localparam op_t OP_GOTO = op_t'(16);
  localparam op_t OP_IFGT = op_t'(21);
  localparam op_t OP_NOP  = op_t'(0);

  localparam logic [PC_WIDTH-1:0] ADDR_MAX = '1;

  state_t state, state_n;
  logic [PC_WIDTH-1:0] addr;
  logic hs, is_reg, is_lit, is_br, is_nop, rsvd;
  logic wr_n, clr;
  logic [1:0] err_n;
  logic [PROGRAM_DataWidth-1:0] enc;

  assign hs = s.in_valid & s.in_ready;

  assign is_reg = s.in_opcode >= OP_ADD && s.in_opcode <= OP_REGL;
  assign is_lit = s.in_opcode >= OP_SHL && s.in_opcode <= OP_VAL;
  assign is_br  = s.in_opcode >= OP_GOTO && s.in_opcode <= OP_IFGT;
  assign is_nop = s.in_opcode == OP_NOP;
  assign rsvd   = !(is_reg || is_lit || is_br || is_nop);

  always_comb begin
    enc = '0;
    unique case (1'b1)
      is_reg: begin
        enc[PROGRAM_DataWidth-1 -: NumOpCodeBits] = s.in_opcode;
        enc[8 +: SEL_WIDTH] = s.in_op1;
        enc[3 +: SEL_WIDTH] = s.in_op2;
      end
      is_lit: begin
        enc[PROGRAM_DataWidth-1 -: NumOpCodeBits] = s.in_opcode;
        enc[8 +: SEL_WIDTH] = s.in_op1;
        enc[0 +: DataWidth] = s.in_literal;
      end
      is_br: begin
        enc[PROGRAM_DataWidth-1 -: NumOpCodeBits] = s.in_opcode;
        enc[0 +: DataWidth] = s.in_literal;
      end
      default: enc = '0;
    endcase
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE, ERROR: begin
        if (start) state_n = LOAD;
      end
      LOAD: begin
        if (hs) begin
          if (rsvd)                 state_n = ERROR;
          else if (s.in_last)       state_n = DONE;
          else if (addr == ADDR_MAX) state_n = ERROR;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    clr   = start && state != LOAD;
    wr_n  = state == LOAD && hs && !rsvd;
    err_n = err_code;
    if (clr) begin
      err_n = 2'b00;
    end else if (state == LOAD && hs) begin
      if (rsvd)
        err_n = 2'b01;
      else if (!s.in_last && addr == ADDR_MAX)
        err_n = 2'b10;
    end
  end

  // Status is registered from the next state so it tracks state exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      addr        <= '0;
      s.in_ready  <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      word_count  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      err_code    <= 2'b00;
      cpu_hold    <= 1'b1;
    end else begin
      state      <= state_n;
      s.in_ready <= state_n == LOAD;
      busy       <= state_n == LOAD;
      done       <= state_n == DONE;
      error      <= state_n == ERROR;
      cpu_hold   <= state_n != DONE;
      err_code   <= err_n;
      mem_wr_en  <= wr_n;
      if (wr_n) begin
        mem_addr    <= addr;
        mem_wr_data <= enc;
        word_count  <= word_count + 1'b1;
        if (addr != ADDR_MAX) addr <= addr + 1'b1;
      end
      if (clr) begin
        addr       <= '0;
        word_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Table-driven bench for program_loader with a write scoreboard.
// Expected writes are queued at each handshake and popped per write pulse.
module tb_program_loader;

  typedef struct {
    logic [4:0]  op;
    logic [1:0]  op1;
    logic [1:0]  op2;
    logic [7:0]  lit;
    logic        last;
    logic        wr;
    logic [15:0] data;
  } vec_t;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset, start;
  logic mem_wr_en;
  logic [7:0] mem_addr;
  logic [15:0] mem_wr_data;
  logic [8:0] word_count;
  logic busy, done, error, cpu_hold;
  logic [1:0] err_code;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_addr;
  wr_t sbq[$];
  wr_t e;
  vec_t tv[13];

  always #5 clk = ~clk;

  program_loader_if bus ();

  program_loader dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .s(bus),
    .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data),
    .word_count(word_count),
    .busy(busy),
    .done(done),
    .error(error),
    .err_code(err_code),
    .cpu_hold(cpu_hold)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_wr_en) begin
      if (sbq.size() == 0) begin
        chk("unexpected_write_addr", {24'd0, mem_addr}, 32'hFFFF);
      end else begin
        e = sbq.pop_front();
        chk("wr_addr", {24'd0, mem_addr}, {24'd0, e.addr});
        chk("wr_data", {16'd0, mem_wr_data}, {16'd0, e.data});
      end
    end else if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk("missing_write_at", {24'd0, e.addr}, 32'hFFFF);
    end
  end

  task automatic send(input vec_t v);
    int n = 0;
    @(negedge clk);
    bus.in_valid   = 1'b1;
    bus.in_opcode  = v.op;
    bus.in_op1     = v.op1;
    bus.in_op2     = v.op2;
    bus.in_literal = v.lit;
    bus.in_last    = v.last;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      chk("ready_timeout", {31'd0, bus.in_ready}, 1);
      return;
    end
    @(posedge clk);
    if (v.wr) begin
      sbq.push_back('{exp_addr, v.data});
      if (exp_addr != 8'hFF) exp_addr++;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send(tv[i]);
    idle();
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_addr = 8'd0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_wr_en"}, {31'd0, mem_wr_en}, 0);
    chk({tag, "_addr"}, {24'd0, mem_addr}, 0);
    chk({tag, "_data"}, {16'd0, mem_wr_data}, 0);
    chk({tag, "_wc"}, {23'd0, word_count}, 0);
    chk({tag, "_status"},
        {28'd0, busy, done, error, cpu_hold}, 32'h1);
    chk({tag, "_err"}, {30'd0, err_code}, 0);
    chk({tag, "_ready"}, {31'd0, bus.in_ready}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    tv[0]  = '{5'd1,  2'd2, 2'd1, 8'h00, 1'b1, 1'b1, 16'h0A08};
    tv[1]  = '{5'd9,  2'd3, 2'd0, 8'h5A, 1'b0, 1'b1, 16'h4B5A};
    tv[2]  = '{5'd7,  2'd1, 2'd0, 8'h03, 1'b0, 1'b1, 16'h3903};
    tv[3]  = '{5'd5,  2'd0, 2'd2, 8'h00, 1'b0, 1'b1, 16'h2810};
    tv[4]  = '{5'd16, 2'd3, 2'd3, 8'h10, 1'b0, 1'b1, 16'h8010};
    tv[5]  = '{5'd18, 2'd0, 2'd0, 8'hFE, 1'b1, 1'b1, 16'h90FE};
    tv[6]  = '{5'd0,  2'd3, 2'd3, 8'hFF, 1'b0, 1'b1, 16'h0000};
    tv[7]  = '{5'd2,  2'd1, 2'd2, 8'hFF, 1'b0, 1'b1, 16'h1110};
    tv[8]  = '{5'd11, 2'd1, 2'd1, 8'h11, 1'b0, 1'b0, 16'h0000};
    tv[9]  = '{5'd31, 2'd0, 2'd0, 8'h00, 1'b1, 1'b0, 16'h0000};
    tv[10] = '{5'd8,  2'd2, 2'd1, 8'h07, 1'b0, 1'b1, 16'h4207};
    tv[11] = '{5'd21, 2'd0, 2'd0, 8'h80, 1'b0, 1'b1, 16'hA880};
    tv[12] = '{5'd3,  2'd3, 2'd3, 8'h00, 1'b1, 1'b1, 16'h1B18};

    reset = 1'b1;
    start = 1'b0;
    exp_addr = 8'd0;
    bus.in_valid = 1'b0;
    bus.in_opcode = '0;
    bus.in_op1 = '0;
    bus.in_op2 = '0;
    bus.in_literal = '0;
    bus.in_last = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("rst");

    do_start();
    run_range(0, 0);
    chk("t1_done", {31'd0, done}, 1);
    chk("t1_hold", {31'd0, cpu_hold}, 0);
    chk("t1_wc", {23'd0, word_count}, 1);

    do_start();
    run_range(1, 5);
    chk("t2_ready", {31'd0, bus.in_ready}, 0);
    chk("t2_done", {31'd0, done}, 1);
    chk("t2_wc", {23'd0, word_count}, 5);

    do_start();
    run_range(6, 8);
    chk("t3_err", {31'd0, error}, 1);
    chk("t3_code", {30'd0, err_code}, 1);
    chk("t3_hold", {31'd0, cpu_hold}, 1);
    chk("t3_ready", {31'd0, bus.in_ready}, 0);
    chk("t3_wc", {23'd0, word_count}, 2);

    do_start();
    chk("t4_code_clr", {30'd0, err_code}, 0);
    chk("t4_busy", {31'd0, busy}, 1);
    run_range(9, 9);
    chk("t4_err", {31'd0, error}, 1);
    chk("t4_code", {30'd0, err_code}, 1);
    chk("t4_wc", {23'd0, word_count}, 0);

    do_start();
    for (int i = 0; i < 256; i++) begin
      vec_t v;
      v.op   = 5'd9;
      v.op1  = 2'(i % 4);
      v.op2  = 2'd0;
      v.lit  = 8'(i);
      v.last = 1'b0;
      v.wr   = 1'b1;
      v.data = {5'd9, 1'b0, 2'(i % 4), 8'(i)};
      send(v);
    end
    idle();
    chk("t5_err", {31'd0, error}, 1);
    chk("t5_code", {30'd0, err_code}, 2);
    chk("t5_wc", {23'd0, word_count}, 256);
    chk("t5_ready", {31'd0, bus.in_ready}, 0);
    repeat (3) @(negedge clk);

    do_start();
    send(tv[1]);
    send(tv[2]);
    @(negedge clk);
    bus.in_valid   = 1'b1;
    bus.in_opcode  = tv[3].op;
    bus.in_op1     = tv[3].op1;
    bus.in_op2     = tv[3].op2;
    bus.in_literal = tv[3].lit;
    bus.in_last    = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    check_reset_vals("t6");
    @(negedge clk);
    chk("t6_idle_wr", {31'd0, mem_wr_en}, 0);
    do_start();
    run_range(0, 0);
    chk("t6_reload_done", {31'd0, done}, 1);

    @(negedge clk);
    bus.in_valid   = 1'b1;
    bus.in_opcode  = tv[10].op;
    bus.in_op1     = tv[10].op1;
    bus.in_op2     = tv[10].op2;
    bus.in_literal = tv[10].lit;
    bus.in_last    = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_addr = 8'd0;
    chk("t7_hold", {31'd0, cpu_hold}, 1);
    chk("t7_code", {30'd0, err_code}, 0);
    chk("t7_ready", {31'd0, bus.in_ready}, 1);
    @(posedge clk);
    sbq.push_back('{exp_addr, tv[10].data});
    exp_addr++;
    run_range(11, 12);
    chk("t7_done", {31'd0, done}, 1);
    chk("t7_wc", {23'd0, word_count}, 3);

    repeat (3) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the instruction path. Accepts symbolic instruction fields over a valid/ready stream and encodes each one into the 16-bit program word format that the CPU decoder reads.
- Writes encoded words sequentially into program memory starting at address 0.
- Holds the CPU until the load completes without error.

Parameters:
PC_WIDTH, 8, program memory address width (2^PC_WIDTH words)
PROGRAM_DataWidth, 16, encoded instruction word width
NumOpCodeBits, 5, opcode field width
SEL_WIDTH, 2, register select field width
DataWidth, 8, literal/param field width

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  begin a load at address 0 (accepted in IDLE, DONE, ERROR)
in_valid  input  1  instruction fields valid
in_ready  output  1  loader can accept fields
in_opcode  input  NumOpCodeBits  opcode
in_op1  input  SEL_WIDTH  operand 1 / destination register
in_op2  input  SEL_WIDTH  operand 2 / source register
in_literal  input  DataWidth  literal, shift amount or branch target/offset
in_last  input  1  this is the final instruction of the program
mem_wr_en  output  1  program memory write strobe
mem_addr  output  PC_WIDTH  program memory write address
mem_wr_data  output  PROGRAM_DataWidth  encoded instruction word
word_count  output  PC_WIDTH+1  number of words written in the current load
busy  output  1  load in progress (state LOAD)
done  output  1  load completed successfully (state DONE)
error  output  1  load aborted (state ERROR)
err_code  output  2  00 none, 01 reserved opcode, 10 address overflow
cpu_hold  output  1  hold the CPU; low only in DONE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. All state and outputs are registered.
- Reset values:
  - State is IDLE.
  - mem_wr_en, mem_addr, mem_wr_data, word_count, busy, done, error and err_code are all 0.
  - cpu_hold is 1.
  - Reset in the middle of a load aborts it immediately. The write pipeline is flushed, so no mem_wr_en pulse occurs in the cycle after reset.
- States:
  - IDLE: start goes to LOAD, and clears word_count and the address counter.
  - LOAD: in_ready = 1. Each handshake (in_valid & in_ready) consumes one instruction.
  - DONE: only start (goes to LOAD) or reset leaves this state.
  - ERROR: only start (goes to LOAD, clearing err_code) or reset leaves this state.
- in_ready = (state == LOAD), driven from a register. It falls in the cycle after the last or erroring handshake.
- start while in LOAD is ignored.
- Encoding, with bits not listed below forced to 0:
  - ADD/SUB/AND/OR/XOR/NOT: [15:11] = opcode, [9:8] = op1, [4:3] = op2. For NOT, op1 is the destination and op2 the source.
  - SHL/SHR/VAL: [15:11] = opcode, [9:8] = op1, [7:0] = literal.
  - GOTO/IFZ/IFNZ/IFEQ/IFST/IFGT: [15:11] = opcode, [7:0] = literal.
  - NOP: 16'h0000. Its fields are ignored.
  - Reserved opcodes 01010–01111 and 10110–11111: nothing is written. State goes to ERROR with err_code = 01.
- Write latency:
  - A handshake in cycle N gives mem_wr_en = 1 in cycle N+1, with mem_addr = the current address and mem_wr_data = the encoded word.
  - Full throughput is supported: one word per cycle.
  - mem_wr_en is a single-cycle pulse per word.
  - mem_addr and mem_wr_data hold their last values while mem_wr_en = 0.
- Counters: the address increments after every write. word_count increments together with mem_wr_en.
- Accepted word with in_last = 1: the word is written and state goes to DONE.
- Overflow:
  - A word accepted at address 2^PC_WIDTH-1 with in_last = 0 is still written.
  - State then goes to ERROR with err_code = 10. The address does not wrap to 0.
- Simultaneous events:
  - A reserved opcode with in_last = 1 still causes ERROR (err_code = 01).
  - A reserved opcode takes priority over overflow.
  - reset takes priority over start and over any handshake.
- Status outputs: busy, done and error are one-hot decodes of the state. cpu_hold = !(state == DONE).

Test Plan:
- Reset, then start, then ADD op1=2 op2=1 (in_last=1) -> one mem_wr_en pulse with addr 0, data 16'h0A08; then done=1, cpu_hold=0, word_count=1.
- Back-to-back stream VAL r3,0x5A; SHL r1,3; NOT r0,r2; GOTO 0x10; IFNZ 0xFE (last) -> addresses 0..4, data 4B5A, 3903, 2810, 8010, 90FE in consecutive cycles; in_ready=0 after the last.
- NOP with garbage fields -> data 16'h0000. Opcode 5'b01011 as the 3rd word -> only 2 writes, error=1, err_code=01, cpu_hold=1, in_ready=0.
- 256 words with no in_last (PC_WIDTH=8) -> 256 writes at addresses 0..255, then error=1, err_code=10, word_count=256, no write to address 0 again.
- Reset asserted during a stream, one cycle after a handshake -> no mem_wr_en pulse follows; all outputs take reset values; a new start reloads from address 0.
- From DONE, start with in_valid held high -> new load from address 0, cpu_hold returns to 1, err_code=00.
